// File: rtl/mul_man_final.sv
// Final mantissa-multiplier stage: resolves the carry-save pair, normalizes to 12 bits,
// rounds to nearest-even and reports the exponent increment. Optional MUL_RAW_PROD_EN adds out_prod.
module mul_man_final #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_sum,
  input  logic [18:0]      in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_man,
  output logic [1:0]       out_exp_inc,
  output logic             out_zero,
  output logic             out_unnorm,
`ifdef MUL_RAW_PROD_EN
  output logic [23:0]      out_prod,
`endif
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a side only when valid & ready are both high
  // at the clock edge. Once valid is raised, the producer holds it and its data until
  // the transfer. in_ready is combinational from out_ready (no skid buffer).
  logic             s1_valid;
  logic [23:0]      s1_sum;
  logic [18:0]      s1_carry;
  logic [TAG_W-1:0] s1_tag;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  logic [18:0] prod_hi;
  logic [23:0] prod;
  logic [11:0] m;
  logic        g;
  logic        st;
  logic        e;
  logic        up;
  logic [11:0] man_n;
  logic [1:0]  inc_n;
  logic        zero_n;
  logic        unnorm_n;

  always_comb begin
    prod_hi  = s1_sum[23:5] + s1_carry;
    prod     = {prod_hi, s1_sum[4:0]};
    m        = prod[22:11];
    g        = prod[10];
    st       = |prod[9:0];
    e        = 1'b0;
    if (prod[23]) begin
      m  = prod[23:12];
      g  = prod[11];
      st = |prod[10:0];
      e  = 1'b1;
    end
    up       = g & (st | m[0]);
    man_n    = m + {11'd0, up};
    inc_n    = {1'b0, e};
    // Rounding 12'hFFF up carries out of the mantissa: renormalize to 1.0
    if (up && (m == 12'hFFF)) begin
      man_n = 12'h800;
      inc_n = {1'b0, e} + 2'd1;
    end
    zero_n   = (prod == 24'd0);
    unnorm_n = (prod[23:22] == 2'b00) && !zero_n;
    if (zero_n) begin
      man_n = 12'd0;
      inc_n = 2'd0;
    end
  end

  // S1: capture the carry-save pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum   <= in_sum;
        s1_carry <= in_carry;
        s1_tag   <= in_tag;
      end
    end
  end

  // S2: capture the rounded result; a bubble from S1 clears out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_man     <= '0;
      out_exp_inc <= '0;
      out_zero    <= 1'b0;
      out_unnorm  <= 1'b0;
      out_tag     <= '0;
`ifdef MUL_RAW_PROD_EN
      out_prod    <= '0;
`endif
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_man     <= man_n;
        out_exp_inc <= inc_n;
        out_zero    <= zero_n;
        out_unnorm  <= unnorm_n;
        out_tag     <= s1_tag;
`ifdef MUL_RAW_PROD_EN
        out_prod    <= prod;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mul_man_final.sv
// Self-checking bench for mul_man_final: directed cases, backpressure, mid-stream reset
// and randomized traffic scored against an arithmetic reference model.
module tb_mul_man_final;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sum;
  logic [18:0] in_carry;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_man;
  logic [1:0]  out_exp_inc;
  logic        out_zero;
  logic        out_unnorm;
  logic [7:0]  out_tag;
`ifdef MUL_RAW_PROD_EN
  logic [23:0] out_prod;
`endif

  mul_man_final #(.TAG_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_man    (out_man),
    .out_exp_inc(out_exp_inc),
    .out_zero   (out_zero),
    .out_unnorm (out_unnorm),
`ifdef MUL_RAW_PROD_EN
    .out_prod   (out_prod),
`endif
    .out_tag    (out_tag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bundle = {tag, man, exp_inc, zero, unnorm}
  function automatic logic [23:0] model(input logic [23:0] s, input logic [18:0] c,
                                        input logic [7:0] t);
    int unsigned p, sh, mm, rem, half, ee;
    logic up, uu;
    p = (int'(s) + (int'(c) << 5)) % (1 << 24);
    if (p == 0) return {t, 12'd0, 2'd0, 1'b1, 1'b0};
    ee   = (p >= (1 << 23)) ? 1 : 0;
    sh   = ee ? 12 : 11;
    mm   = p >> sh;
    rem  = p & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && (mm % 2 == 1));
    mm   = mm + up;
    if (mm == 4096) begin
      mm = 2048;
      ee = ee + 1;
    end
    uu = (p < (1 << 22));
    return {t, mm[11:0], ee[1:0], 1'b0, uu};
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [23:0] out_bundle;
  logic [23:0] prev_bundle;
  logic        prev_stall = 1'b0;
  logic        saw_in_ready_low = 1'b0;

  assign out_bundle = {out_tag, out_man, out_exp_inc, out_zero, out_unnorm};

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", out_bundle, prev_bundle);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
        else check("out_bundle", out_bundle, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_carry, in_tag));
      if (in_valid && !in_ready) saw_in_ready_low = 1'b1;
      prev_stall  = out_valid && !out_ready;
      prev_bundle = out_bundle;
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] dir_tag = 8'h80;

  // Call at posedge+1 with an empty pipe; checks 2-cycle latency and the result.
  task automatic directed(input string name, input logic [23:0] s, input logic [18:0] c,
                          input logic [11:0] em, input logic [1:0] ee,
                          input logic ez, input logic eu);
    in_valid  = 1'b1;
    in_sum    = s;
    in_carry  = c;
    in_tag    = dir_tag;
    dir_tag   = dir_tag + 8'd1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_man"}, out_man, em);
    check({name, "_inc"}, out_exp_inc, ee);
    check({name, "_zero"}, out_zero, ez);
    check({name, "_unnorm"}, out_unnorm, eu);
  endtask

  function automatic logic [23:0] gen_sum();
    logic [23:0] r;
    r = 24'($urandom);
    case ($urandom_range(0, 5))
      0: gen_sum = 24'd0;
      1: gen_sum = (r & 24'hFFF800) | 24'h400400;
      2: gen_sum = 24'($urandom_range(0, 24'h3FFFFF));
      3: gen_sum = 24'h7FFC00 | (r & 24'h8003FF);
      default: gen_sum = r;
    endcase
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  logic acc;
  int   next_tag;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_man", out_man, 12'd0);
    check("rst_out_exp_inc", out_exp_inc, 2'd0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_out_unnorm", out_unnorm, 1'b0);
    check("rst_out_tag", out_tag, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    directed("one_x_one", 24'h3FFFE0, 19'h1, 12'h800, 2'd0, 1'b0, 1'b0);
    directed("max_ops",   24'hFFE001, 19'h0, 12'hFFE, 2'd1, 1'b0, 1'b0);
    directed("tie_odd",   24'h400C00, 19'h0, 12'h802, 2'd0, 1'b0, 1'b0);
    directed("tie_even",  24'h400400, 19'h0, 12'h800, 2'd0, 1'b0, 1'b0);
    directed("rnd_ovf",   24'h7FFC00, 19'h0, 12'h800, 2'd1, 1'b0, 1'b0);
    directed("zero",      24'h000000, 19'h0, 12'h000, 2'd0, 1'b1, 1'b0);
    directed("unnorm",    24'h000800, 19'h0, 12'h001, 2'd0, 1'b0, 1'b1);
    directed("ovf_hi",    24'hFFF800, 19'h0, 12'h800, 2'd2, 1'b0, 1'b0);
    directed("carry_wrap", 24'hFFFFE0, 19'h1, 12'h000, 2'd0, 1'b1, 1'b0);
    drain();

    // Backpressure: tags 1..4 with out_ready low for cycles 3..6
    saw_in_ready_low = 1'b0;
    next_tag = 1;
    for (int i = 0; i < 14; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      in_valid  = (next_tag <= 4);
      in_sum    = 24'h400000 | (24'(next_tag) << 11);
      in_carry  = 19'h0;
      in_tag    = 8'(next_tag);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) next_tag++;
    end
    check("bp_in_ready_fell", saw_in_ready_low, 1'b1);
    check("bp_all_sent", next_tag, 5);
    drain();

    // Mid-stream reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum   = gen_sum();
      in_carry = 19'($urandom);
      in_tag   = 8'h40 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rstm_full_out_valid", out_valid, 1'b1);
    check("rstm_full_in_ready", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rstm_async_out_valid", out_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstm_no_stale", out_valid, 1'b0);
    end
    directed("post_rst", 24'h400C00, 19'h0, 12'h802, 2'd0, 1'b0, 1'b0);
    drain();

    // Randomized traffic; data held while offered and not accepted
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sum   = gen_sum();
        in_carry = ($urandom_range(0, 1) != 0) ? 19'($urandom) : 19'h0;
        in_tag   = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_man_final.md
Name: mul_man_final

Overview:
- Pipelined final stage of the mantissa multiplier. Sits directly downstream of the carry-save compressor tree.
- Registers the carry-save pair (sum 24b, carry 19b aligned at bit 5) and resolves it with a carry-propagate add.
- Normalizes the 24-bit product to a 12-bit mantissa (hidden bit included), rounds to nearest-even and reports the exponent increment.
- Valid/ready handshake on both sides; a sideband tag (sign/exponent/id) travels with each product.

Parameters:
- TAG_W, 8, width of sideband tag carried alongside each product unchanged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  carry-save pair valid
- in_ready  out  1  stage can accept pair this cycle
- in_sum  in  24  compressor sum vector, weight 2^0..2^23
- in_carry  in  19  compressor carry vector, weight 2^5..2^23
- in_tag  in  TAG_W  sideband, passed through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_man  out  12  rounded normalized mantissa, bit 11 = hidden bit
- out_exp_inc  out  2  exponent increment (0, 1 or 2)
- out_zero  out  1  product is exactly zero
- out_unnorm  out  1  prod[23:22]==0 and product nonzero (subnormal input); mantissa left unshifted
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async, rst_n low): s1_valid=0, s2_valid=0, out_valid=0, out_man=0, out_exp_inc=0, out_zero=0, out_unnorm=0, out_tag=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation flushes both stages and drops all in-flight products. No output follows.
- Pipeline:
  - S1 registers in_sum, in_carry and in_tag.
  - S2 registers the rounded result.
  - Latency is 2 cycles from accepted input to out_valid when out_ready=1.
  - Throughput is 1 per cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- Transfers occur only on valid&ready. While out_valid & !out_ready, every out_* signal holds stable.
- A bubble in S1 with s2_adv=1 clears s2_valid.
- Add (S1→S2 combinational path):
  - prod[4:0] = s1_sum[4:0]
  - prod[23:5] = s1_sum[23:5] + s1_carry, modulo 2^19, carry-out discarded
- Normalize:
  - If prod[23]=1: m = prod[23:12], g = prod[11], st = |prod[10:0], e = 1.
  - Otherwise: m = prod[22:11], g = prod[10], st = |prod[9:0], e = 0.
- Round (RNE): up = g & (st | m[0]).
  - If up and m==12'hFFF: out_man = 12'h800, out_exp_inc = e+1.
  - Else: out_man = m+up, out_exp_inc = e.
- Zero: if prod==0, then out_zero=1, out_man=0, out_exp_inc=0, out_unnorm=0.
- Unnormalized: if prod[23:22]==0 and prod!=0, then out_unnorm=1 and the e=0 path is used unchanged.

Optional Feature:
- Macro MUL_RAW_PROD_EN.
- When defined: adds output port out_prod (24b), holding the unrounded prod registered in S2 with the same valid/stall rules. Reset value 0.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- 1.0×1.0 via carry: in_sum=24'h3FFFE0, in_carry=19'h1, out_ready=1 → 2 cycles later: out_man=12'h800, out_exp_inc=0, out_zero=0.
- Max operands: in_sum=24'hFFE001, in_carry=0 → out_man=12'hFFE, out_exp_inc=1.
- Rounding:
  - in_sum=24'h400C00 → out_man=12'h802 (tie, odd lsb, rounds up).
  - in_sum=24'h400400 → out_man=12'h800 (tie, even lsb, holds).
  - in_sum=24'h7FFC00 → out_man=12'h800, out_exp_inc=1 (round overflow).
- Zero and unnormalized:
  - in_sum=0, in_carry=0 → out_zero=1, out_man=0.
  - in_sum=24'h000800 → out_unnorm=1, out_man=12'h001.
- Backpressure: stream 4 tagged products (tags 1..4) with out_ready low for cycles 3–6 → in_ready falls once S1 and S2 are full. Outputs hold stable while stalled, then tags emerge in order 1,2,3,4 with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with both stages valid → out_valid=0 immediately (async). No stale result appears after release. A product issued after release emerges with latency 2.
